// File: rtl/kyber_pkg.sv
// Shared constants and types for the Kyber uniform rejection sampler.
package kyber_pkg;

   localparam int KYBER_N = 256;
   localparam int COEFF_W = 12;
   localparam int DATA_W  = 128;

   localparam logic [COEFF_W-1:0] KYBER_Q = 12'd3329;

   typedef enum logic {
      IDLE = 1'b0,
      RUN  = 1'b1
   } smp_state_t;

endpackage

// File: rtl/kyber_rej_sampler_if.sv
// Squeeze-word input and coefficient output handshakes of the sampler.
interface kyber_rej_sampler_if;
   import kyber_pkg::*;

   logic               valid_in;
   logic [DATA_W-1:0]  data_in;
   logic               data_ready;
   logic [COEFF_W-1:0] coeff_out;
   logic [7:0]         coeff_idx;
   logic               valid_out;
   logic               coeff_ready;

   modport slave (
      input  valid_in, data_in, coeff_ready,
      output data_ready, coeff_out, coeff_idx, valid_out
   );

   modport master (
      output valid_in, data_in, coeff_ready,
      input  data_ready, coeff_out, coeff_idx, valid_out
   );

endinterface

// File: rtl/kyber_rej_parse.sv
// Splits three stream bytes into two 12-bit candidates and flags those below Q.
module kyber_rej_parse
   import kyber_pkg::*;
(
   input  logic [23:0]        trip,
   output logic [COEFF_W-1:0] d1,
   output logic [COEFF_W-1:0] d2,
   output logic               v1,
   output logic               v2
);

   assign d1 = trip[11:0];
   assign d2 = trip[23:12];
   assign v1 = d1 < KYBER_Q;
   assign v2 = d2 < KYBER_Q;

endmodule

// File: rtl/kyber_rej_sampler.sv
// Kyber Parse: 18-byte stream buffer, two candidate slots, coefficient counter.
module kyber_rej_sampler
   import kyber_pkg::*;
(
   input  logic                clk,
   input  logic                reset_n,
   input  logic                start,
   kyber_rej_sampler_if.slave  bus,
   output logic                busy,
   output logic                done
);

   localparam int BUF_W  = DATA_W + 16;
   localparam int WORD_B = DATA_W / 8;

   smp_state_t         state_q, state_d;
   logic [BUF_W-1:0]   sbuf_q, sbuf_d;
   logic [BUF_W-1:0]   shifted;
   logic [4:0]         bcnt_q, bcnt_d;
   logic [4:0]         base;
   logic [COEFF_W-1:0] s1_q, s1_d, s2_q, s2_d;
   logic               s1v_q, s1v_d, s2v_q, s2v_d;
   logic [8:0]         cnt_q, cnt_d;
   logic               done_q, done_d;
   logic               run, word_acc, fire, last;
   logic [COEFF_W-1:0] d1, d2;
   logic               v1, v2;

   kyber_rej_parse u_parse (
      .trip (sbuf_q[23:0]),
      .d1   (d1),
      .d2   (d2),
      .v1   (v1),
      .v2   (v2)
   );

   assign run            = state_q == RUN;
   assign bus.data_ready = run && (bcnt_q <= 5'd2);
   assign bus.valid_out  = run && (s1v_q || s2v_q);
   assign bus.coeff_out  = s1v_q ? s1_q : s2_q;
   assign bus.coeff_idx  = cnt_q[7:0];
   assign word_acc       = bus.valid_in && bus.data_ready;
   assign fire           = bus.valid_out && bus.coeff_ready;
   assign last           = cnt_q == 9'(KYBER_N - 1);
   assign busy           = run;
   assign done           = done_q;

   always_comb begin
      state_d = state_q;
      sbuf_d  = sbuf_q;
      bcnt_d  = bcnt_q;
      s1_d    = s1_q;
      s2_d    = s2_q;
      s1v_d   = s1v_q;
      s2v_d   = s2v_q;
      cnt_d   = cnt_q;
      done_d  = 1'b0;
      shifted = sbuf_q;
      base    = bcnt_q;
      if (start) begin
         state_d = RUN;
         sbuf_d  = '0;
         bcnt_d  = '0;
         s1v_d   = 1'b0;
         s2v_d   = 1'b0;
         cnt_d   = '0;
      end else if (run) begin
         if (fire) begin
            cnt_d = cnt_q + 9'd1;
            if (s1v_q) s1v_d = 1'b0;
            else       s2v_d = 1'b0;
         end
         if (fire && last) begin
            state_d = IDLE;
            done_d  = 1'b1;
            sbuf_d  = '0;
            bcnt_d  = '0;
            s1v_d   = 1'b0;
            s2v_d   = 1'b0;
         end else begin
            // refill only once both slots drain, so a rejected pair costs one cycle
            if (bcnt_q >= 5'd3 && !s1v_d && !s2v_d) begin
               shifted = sbuf_q >> 24;
               base    = bcnt_q - 5'd3;
               s1_d    = d1;
               s2_d    = d2;
               s1v_d   = v1;
               s2v_d   = v2;
            end
            sbuf_d = shifted;
            bcnt_d = base;
            if (word_acc) begin
               sbuf_d = shifted |
                  ({{(BUF_W-DATA_W){1'b0}}, bus.data_in}
                   << {base, 3'b000});
               bcnt_d = base + 5'(WORD_B);
            end
         end
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= IDLE;
         sbuf_q  <= '0;
         bcnt_q  <= '0;
         s1_q    <= '0;
         s2_q    <= '0;
         s1v_q   <= 1'b0;
         s2v_q   <= 1'b0;
         cnt_q   <= '0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         sbuf_q  <= sbuf_d;
         bcnt_q  <= bcnt_d;
         s1_q    <= s1_d;
         s2_q    <= s2_d;
         s1v_q   <= s1v_d;
         s2v_q   <= s2v_d;
         cnt_q   <= cnt_d;
         done_q  <= done_d;
      end
   end

endmodule

// File: tb/tb_kyber_rej_sampler.sv
// Scoreboard bench for kyber_rej_sampler against a byte-queue Parse model.
module tb_kyber_rej_sampler;
   import kyber_pkg::*;

   logic clk     = 1'b0;
   logic reset_n = 1'b1;
   logic start   = 1'b0;
   logic busy;
   logic done;

   kyber_rej_sampler_if bus ();

   kyber_rej_sampler dut (
      .clk     (clk),
      .reset_n (reset_n),
      .start   (start),
      .bus     (bus),
      .busy    (busy),
      .done    (done)
   );

   always #5 clk = ~clk;

   int checks   = 0;
   int failures = 0;
   int exp_c[$];
   int exp_i[$];
   int bq[$];
   int produced  = 0;
   int seen      = 0;
   int stall_left = 0;
   int rdy_pct   = 100;
   bit done_exp  = 1'b0;
   bit poly_done = 1'b0;

   task automatic chk(input string name, input int got, input int want);
      checks++;
      if (got != want) begin
         failures++;
         $display("FAIL %s got=%0d expected=%0d", name, got, want);
      end
   endtask

   function automatic void model_clear();
      exp_c.delete();
      exp_i.delete();
      bq.delete();
      produced = 0;
   endfunction

   function automatic void take(input int d);
      if (produced < 256 && d < 3329) begin
         exp_c.push_back(d);
         exp_i.push_back(produced);
         produced++;
      end
   endfunction

   // Parse as written in the standard: 3 bytes -> two 12-bit values
   function automatic void model_word(input logic [127:0] w);
      for (int b = 0; b < 16; b++)
         bq.push_back(int'(w[8*b +: 8]));
      while (bq.size() >= 3) begin
         int b0, b1, b2;
         b0 = bq.pop_front();
         b1 = bq.pop_front();
         b2 = bq.pop_front();
         take(b0 + 256 * (b1 % 16));
         take(b1 / 16 + 16 * b2);
      end
   endfunction

   function automatic logic [127:0] rand_word();
      return {$urandom(), $urandom(), $urandom(), $urandom()};
   endfunction

   task automatic send_word(input logic [127:0] w, input int pct);
      int waited = 0;
      bus.data_in = w;
      while (!poly_done) begin
         bus.valid_in = ($urandom_range(99) < pct);
         if (bus.valid_in && bus.data_ready) begin
            model_word(w);
            @(posedge clk); #1;
            bus.valid_in = 1'b0;
            return;
         end
         @(posedge clk); #1;
         waited++;
         if (waited > 300) begin
            chk("word_timeout", waited, 0);
            bus.valid_in = 1'b0;
            return;
         end
      end
      bus.valid_in = 1'b0;
   endtask

   task automatic do_start();
      bus.valid_in = 1'b0;
      start = 1'b1;
      model_clear();
      poly_done = 1'b0;
      done_exp  = 1'b0;
      seen      = 0;
      @(posedge clk); #1;
      start = 1'b0;
   endtask

   task automatic feed_until_done();
      for (int k = 0; k < 200 && !poly_done; k++)
         send_word(rand_word(), 85);
      chk("poly_done", int'(poly_done), 1);
      chk("queue_drained", exp_c.size(), 0);
   endtask

   // coefficient sink with random back-pressure and forced stalls
   initial begin
      bus.coeff_ready = 1'b0;
      forever begin
         @(posedge clk); #1;
         if (stall_left > 0) begin
            bus.coeff_ready = 1'b0;
            stall_left--;
         end else begin
            bus.coeff_ready = ($urandom_range(99) < rdy_pct);
         end
      end
   end

   // monitor / scoreboard
   initial begin
      forever begin
         @(negedge clk);
         if (!reset_n) begin
            chk("reset_outputs",
                int'({bus.data_ready, bus.valid_out, busy, done,
                      bus.coeff_out, bus.coeff_idx}), 0);
         end else if (!start) begin
            if (done_exp) begin
               chk("done_pulse", int'(done), 1);
               chk("idle_after_done",
                   int'({busy, bus.data_ready, bus.valid_out}), 0);
               done_exp  = 1'b0;
               poly_done = 1'b1;
            end else begin
               chk("done_low", int'(done), 0);
            end
            if (bus.valid_out) begin
               if (exp_c.size() == 0) begin
                  chk("spurious_valid", int'(bus.valid_out), 0);
               end else begin
                  chk("coeff", int'(bus.coeff_out), exp_c[0]);
                  chk("idx", int'(bus.coeff_idx), exp_i[0]);
                  if (bus.coeff_ready) begin
                     if (exp_i[0] == 255) done_exp = 1'b1;
                     void'(exp_c.pop_front());
                     void'(exp_i.pop_front());
                     seen++;
                  end
               end
            end
         end
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog got=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [127:0] w;
      bus.valid_in = 1'b0;
      bus.data_in  = '0;
      model_clear();
      #2 reset_n = 1'b0;
      repeat (3) @(posedge clk);
      #1 reset_n = 1'b1;
      @(posedge clk); #1;

      // bytes 00..0F, first coefficient one edge after word edge
      do_start();
      for (int b = 0; b < 16; b++) w[8*b +: 8] = 8'(b);
      send_word(w, 100);
      @(negedge clk);
      chk("latency_pre", int'(bus.valid_out), 0);
      @(negedge clk);
      chk("latency_post", int'(bus.valid_out), 1);
      chk("first_coeff", int'(bus.coeff_out), 256);
      chk("first_idx", int'(bus.coeff_idx), 0);
      @(posedge clk); #1;

      // aligns after leftover 0x0F: rejects FFFFFF and 01DDD0, then 3328, 0
      w = rand_word();
      w[87:0] = 88'h00_0D_00_D0_DD_01_FF_FF_FF_00_00;
      send_word(w, 100);
      rdy_pct = 70;
      stall_left = 10;
      feed_until_done();

      // words offered while idle are ignored
      bus.valid_in = 1'b1;
      bus.data_in  = rand_word();
      repeat (3) begin
         @(negedge clk);
         chk("idle_ready", int'(bus.data_ready), 0);
         chk("idle_valid", int'(bus.valid_out), 0);
      end
      @(posedge clk); #1;
      bus.valid_in = 1'b0;

      // reset after 100 coefficients, then a clean polynomial
      do_start();
      for (int k = 0; k < 100 && seen < 100; k++)
         send_word(rand_word(), 85);
      chk("reached_100", int'(seen >= 100), 1);
      reset_n = 1'b0;
      bus.valid_in = 1'b0;
      model_clear();
      done_exp = 1'b0;
      @(negedge clk);
      chk("mid_reset_busy", int'(busy), 0);
      chk("mid_reset_idx", int'(bus.coeff_idx), 0);
      repeat (2) @(posedge clk);
      #1 reset_n = 1'b1;
      @(posedge clk); #1;
      do_start();
      stall_left = 10;
      feed_until_done();

      // restart while running with bytes still buffered
      do_start();
      send_word(rand_word(), 100);
      repeat (3) @(posedge clk);
      #1;
      do_start();
      @(negedge clk);
      chk("restart_valid", int'(bus.valid_out), 0);
      chk("restart_idx", int'(bus.coeff_idx), 0);
      @(posedge clk); #1;
      feed_until_done();
      @(negedge clk);
      chk("final_ready", int'(bus.data_ready), 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
